// File: rtl/aclk_load_arbiter.sv
// Round-robin arbiter that shares the alarm clock's configuration port between two requesters.
// Validates the requested HH:MM and sequences data setup, load strobe and guard time.
module aclk_load_arbiter #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 2,
  parameter int GUARD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  kind,
  input  logic [13:0] hhmm0,
  input  logic [13:0] hhmm1,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic        busy,
  output logic [1:0]  H_in1,
  output logic [3:0]  H_in0,
  output logic [3:0]  M_in1,
  output logic [3:0]  M_in0,
  output logic        LD_time,
  output logic        LD_alarm,
  output logic [2:0]  dbg_state
);

  localparam int MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_SH > GUARD_CYCLES) ? MAX_SH : GUARD_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_SETUP   = 3'd2,
    S_LOAD    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Handshake: a requester raises req[i] with stable kind/hhmm and holds it
  // until it sees ack[i] or err[i]; it drops req during that pulse cycle.
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    req_q, req_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          kind_q, kind_d;
  logic [13:0]   hhmm_q, hhmm_d;
  logic [13:0]   data_q, data_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic          busy_q, busy_d;
  logic          ld_time_q, ld_time_d;
  logic          ld_alarm_q, ld_alarm_d;
  logic          g;
  logic          valid;

  logic [1:0] h1;
  logic [3:0] h0, m1, m0;

  assign h1 = hhmm_q[13:12];
  assign h0 = hhmm_q[11:8];
  assign m1 = hhmm_q[7:4];
  assign m0 = hhmm_q[3:0];

  assign valid = (h1 <= 2'd2) && (h0 <= 4'd9) && !((h1 == 2'd2) && (h0 > 4'd3)) &&
                 (m1 <= 4'd5) && (m0 <= 4'd9);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req;
    last_d  = last_q;
    gnt_d   = gnt_q;
    kind_d  = kind_q;
    hhmm_d  = hhmm_q;
    data_d  = data_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    g       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_q) begin
          g       = (req_q == 2'b11) ? ~last_q : req_q[1];
          gnt_d   = g;
          last_d  = g;
          kind_d  = kind[g];
          hhmm_d  = g ? hhmm1 : hhmm0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (valid) begin
          data_d  = hhmm_q;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end else begin
          err_d[gnt_q] = 1'b1;
          // The rejected requester's stale sample must not be re-granted.
          req_d[gnt_q] = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          ack_d[gnt_q] = 1'b1;
          req_d[gnt_q] = 1'b0;
          cnt_d        = GUARD_LD;
          state_d      = S_RELEASE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d != S_IDLE);
    ld_time_d  = (state_d == S_LOAD) && !kind_q;
    ld_alarm_d = (state_d == S_LOAD) && kind_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 2'b00;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      kind_q     <= 1'b0;
      hhmm_q     <= '0;
      data_q     <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      busy_q     <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      kind_q     <= kind_d;
      hhmm_q     <= hhmm_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign H_in1     = data_q[13:12];
  assign H_in0     = data_q[11:8];
  assign M_in1     = data_q[7:4];
  assign M_in0     = data_q[3:0];
  assign LD_time   = ld_time_q;
  assign LD_alarm  = ld_alarm_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aclk_load_arbiter.sv
// Bench for aclk_load_arbiter: a default-timed instance and a SETUP=3/HOLD=1/GUARD=2 instance,
// checked every cycle against a schedule-based model plus directed literal expectations.
module tb_aclk_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v  [2];
  logic [1:0]  kind_v [2];
  logic [13:0] hv     [2][2];
  logic [1:0]  ack_v  [2];
  logic [1:0]  err_v  [2];
  logic        busy_v [2];
  logic [1:0]  h1o_v  [2];
  logic [3:0]  h0o_v  [2];
  logic [3:0]  m1o_v  [2];
  logic [3:0]  m0o_v  [2];
  logic        lt_v   [2];
  logic        la_v   [2];
  logic [2:0]  dbg_v  [2];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  aclk_load_arbiter #(.SETUP_CYCLES(1), .HOLD_CYCLES(2), .GUARD_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .kind(kind_v[0]),
    .hhmm0(hv[0][0]), .hhmm1(hv[0][1]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]),
    .H_in1(h1o_v[0]), .H_in0(h0o_v[0]), .M_in1(m1o_v[0]), .M_in0(m0o_v[0]),
    .LD_time(lt_v[0]), .LD_alarm(la_v[0]), .dbg_state(dbg_v[0])
  );

  aclk_load_arbiter #(.SETUP_CYCLES(3), .HOLD_CYCLES(1), .GUARD_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .kind(kind_v[1]),
    .hhmm0(hv[1][0]), .hhmm1(hv[1][1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]),
    .H_in1(h1o_v[1]), .H_in0(h0o_v[1]), .M_in1(m1o_v[1]), .M_in0(m0o_v[1]),
    .LD_time(lt_v[1]), .LD_alarm(la_v[1]), .dbg_state(dbg_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] outv(input int i);
    return {ack_v[i], err_v[i], busy_v[i], h1o_v[i], h0o_v[i], m1o_v[i], m0o_v[i], lt_v[i], la_v[i]};
  endfunction

  function automatic logic [13:0] dat(input int i);
    return {h1o_v[i], h0o_v[i], m1o_v[i], m0o_v[i]};
  endfunction

  function automatic int p_s(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int p_h(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_g(input int i); return (i == 0) ? 1 : 2; endfunction

  // A time is legal when every digit is decimal, minutes < 60 and hours < 24.
  function automatic logic ok_time(input logic [13:0] v);
    int hh1, hh0, mm1, mm0;
    hh1 = int'(v[13:12]); hh0 = int'(v[11:8]); mm1 = int'(v[7:4]); mm0 = int'(v[3:0]);
    return (hh0 <= 9) && (mm0 <= 9) && (mm1 <= 5) && (hh1 * 10 + hh0 <= 23);
  endfunction

  // Transaction-level model: each grant at edge t schedules the whole output timeline.
  logic        m_act   [2];
  logic        m_valid [2];
  logic        m_kind  [2];
  logic        m_g     [2];
  logic        m_last  [2];
  logic [1:0]  m_req   [2];
  logic [13:0] m_val   [2];
  logic [13:0] m_data  [2];
  int          m_t     [2];
  int          m_dec_ok[2];
  logic [20:0] e_vec   [2];

  task automatic model_step(input int i);
    int n, s, h, gd, t, done_e, gi;
    logic [1:0] e_ack, e_err;
    logic e_busy, e_lt, e_la;
    n = cyc; s = p_s(i); h = p_h(i); gd = p_g(i);
    if (!reset) begin
      m_act[i] = 1'b0; m_last[i] = 1'b1; m_req[i] = 2'b00; m_dec_ok[i] = 0;
      m_data[i] = '0; e_vec[i] = '0;
      return;
    end
    if (n >= m_dec_ok[i] && m_req[i] != 2'b00) begin
      if (m_req[i] == 2'b11) gi = m_last[i] ? 0 : 1;
      else gi = m_req[i][1] ? 1 : 0;
      m_last[i]  = gi[0];
      m_g[i]     = gi[0];
      m_kind[i]  = kind_v[i][gi];
      m_val[i]   = hv[i][gi];
      m_valid[i] = ok_time(hv[i][gi]);
      m_t[i]     = n;
      m_act[i]   = 1'b1;
      m_dec_ok[i] = m_valid[i] ? n + 2 + s + h + gd : n + 2;
    end
    e_ack = 2'b00; e_err = 2'b00; e_busy = 1'b0; e_lt = 1'b0; e_la = 1'b0; done_e = -1;
    t = m_t[i];
    if (m_act[i]) begin
      if (m_valid[i]) begin
        if (n == t + 1) m_data[i] = m_val[i];
        e_busy = (n >= t) && (n <= t + s + h + gd);
        if (n >= t + 1 + s && n <= t + s + h) begin
          if (m_kind[i]) e_la = 1'b1; else e_lt = 1'b1;
        end
        if (n == t + 1 + s + h) e_ack[m_g[i]] = 1'b1;
        done_e = t + 1 + s + h;
      end else begin
        e_busy = (n == t);
        if (n == t + 1) e_err[m_g[i]] = 1'b1;
        done_e = t + 1;
      end
    end
    m_req[i] = req_v[i];
    if (m_act[i] && n == done_e) m_req[i][m_g[i]] = 1'b0;
    e_vec[i] = {e_ack, e_err, e_busy, m_data[i], e_lt, e_la};
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_vec[i] = '0; m_act[i] = 1'b0; m_last[i] = 1'b1; m_req[i] = 2'b00;
      m_data[i] = '0; m_dec_ok[i] = 0; m_t[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_step(0);
      model_step(1);
    end
  end

  initial begin
    #2;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk($sformatf("cyc%0d_inst%0d", cyc, i), outv(i), reset ? e_vec[i] : 21'd0);
    end
  end

  logic [15:0] p_lt, p_la, p_ack, p_err, p_busy, p_oack;
  logic [13:0] d2;
  logic        dst;

  // Requester r of instance i asks for v; records 16 cycles of outputs (bit k = cycle k).
  task automatic txn(input int i, input int r, input logic kd, input logic [13:0] v);
    hv[i][r] = v; kind_v[i][r] = kd; req_v[i][r] = 1'b1;
    p_lt = '0; p_la = '0; p_ack = '0; p_err = '0; p_busy = '0; p_oack = '0;
    d2 = '0; dst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      p_lt[k]   = lt_v[i];
      p_la[k]   = la_v[i];
      p_ack[k]  = ack_v[i][r];
      p_oack[k] = ack_v[i][(r == 0) ? 1 : 0];
      p_err[k]  = err_v[i][r];
      p_busy[k] = busy_v[i];
      if (k == 2) d2 = dat(i);
      if (k > 2 && k <= 7 && dat(i) != d2) dst = 1'b0;
      if (k == 1) hv[i][r] = ~v;
      if (ack_v[i][r] || err_v[i][r]) req_v[i][r] = 1'b0;
    end
    req_v[i][r] = 1'b0;
    hv[i][r] = v;
  endtask

  logic [13:0] bad [4];
  logic [1:0]  seen;
  logic [3:0]  seq;
  logic [1:0]  dropped;
  int          nack;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 2'b00; kind_v[i] = 2'b00; hv[i][0] = '0; hv[i][1] = '0;
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_0", outv(0), 0);
    chk("reset_state_1", outv(1), 0);
    reset = 1'b1;

    txn(0, 0, 1'b0, 14'h2359);
    chk("a_ltime", p_lt, 16'h0018);
    chk("a_lalarm", p_la, 16'h0000);
    chk("a_ack0", p_ack, 16'h0020);
    chk("a_busy", p_busy, 16'h003E);
    chk("a_data", d2, 14'h2359);

    txn(0, 1, 1'b1, 14'h0730);
    chk("b_lalarm", p_la, 16'h0018);
    chk("b_ltime", p_lt, 16'h0000);
    chk("b_ack1", p_ack, 16'h0020);
    chk("b_ack0", p_oack, 16'h0000);

    bad[0] = 14'h2400; bad[1] = 14'h1260; bad[2] = 14'h0A00; bad[3] = 14'h3000;
    for (int j = 0; j < 4; j++) begin
      txn(0, 0, 1'b0, bad[j]);
      chk($sformatf("inv_err_%0h", bad[j]), p_err, 16'h0004);
      chk($sformatf("inv_strobe_%0h", bad[j]), p_lt | p_la, 16'h0000);
      chk($sformatf("inv_busy_%0h", bad[j]), p_busy, 16'h0002);
      chk($sformatf("inv_data_%0h", bad[j]), d2, 14'h0730);
    end

    txn(0, 0, 1'b1, 14'h1959);
    chk("d_lalarm", p_la, 16'h0018);
    chk("d_data", d2, 14'h1959);

    // Reset while LD_time is high.
    hv[0][0] = 14'h1234; kind_v[0][0] = 1'b0; req_v[0][0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("r_ld_before", lt_v[0], 1);
    #1 reset = 1'b0; req_v[0] = 2'b00;
    #1 chk("r_ld_async", lt_v[0], 0);
    chk("r_outs_zero", outv(0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 2'b00;
    repeat (10) begin
      @(negedge clk);
      seen = seen | ack_v[0];
    end
    chk("r_no_ack", seen, 0);
    txn(0, 1, 1'b0, 14'h0815);
    chk("r_next_ltime", p_lt, 16'h0018);
    chk("r_next_ack1", p_ack, 16'h0020);

    // Fairness from a fresh reset with both requesters always returning.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hv[0][0] = 14'h0100; hv[0][1] = 14'h0200; kind_v[0] = 2'b10; req_v[0] = 2'b11;
    seq = '0; nack = 0; dropped = 2'b00;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (dropped[j]) begin
          req_v[0][j] = 1'b1;
          dropped[j] = 1'b0;
        end else if (ack_v[0][j]) begin
          if (nack < 4) seq[nack] = j[0];
          nack++;
          req_v[0][j] = 1'b0;
          dropped[j] = 1'b1;
        end
      end
    end
    req_v[0] = 2'b00;
    chk("f_count", nack, 4);
    chk("f_order", seq, 4'b1010);
    repeat (20) @(negedge clk);

    txn(1, 0, 1'b0, 14'h1234);
    chk("s_ltime", p_lt, 16'h0020);
    chk("s_lalarm", p_la, 16'h0000);
    chk("s_ack0", p_ack, 16'h0040);
    chk("s_busy", p_busy, 16'h00FE);
    chk("s_data", d2, 14'h1234);
    chk("s_data_stable", dst, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
